// File: rtl/snake_pkg.sv
// Shared types for the snake grid game: grid size, step directions, head FSM
// states and the reverse-direction test.
package snake_pkg;

  localparam int GRID_DIM = 8;

  typedef enum logic [2:0] {DIR_NONE, DIR_U, DIR_D, DIR_L, DIR_R} dir_t;

  typedef enum logic [1:0] {HT_IDLE, HT_RUN, HT_DEAD} ht_state_t;

  // True when b points exactly opposite to a; DIR_NONE has no opposite.
  function automatic logic is_reverse(input dir_t a, input dir_t b);
    case (a)
      DIR_U:   return (b == DIR_D);
      DIR_D:   return (b == DIR_U);
      DIR_L:   return (b == DIR_R);
      DIR_R:   return (b == DIR_L);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/step_tick.sv
// Step-rate divider: while en is high, tick is asserted combinationally on
// the last of every TICK_CYCLES cycles; the count is held at 0 while en is low.
module step_tick #(
  parameter int TICK_CYCLES = 1000
) (
  input  logic Clock,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_CYCLES - 1);

  logic [W-1:0] count;

  assign tick = en && (count == LAST);

  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (!en || tick) begin
      count <= '0;
    end else begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/head_tracker.sv
// Snake head tracker: decodes L/R/U/D levels into a direction and steps the
// head across the 8x8 grid at the step_tick rate. Define HEAD_TRACKER_WRAP_EN
// to wrap at the edges instead of latching a wall collision.
module head_tracker
  import snake_pkg::*;
#(
  parameter int TICK_CYCLES = 1000,
  parameter int START_ROW   = 3,
  parameter int START_COL   = 3
) (
  input  logic                                Clock,
  input  logic                                reset,
  input  logic                                L,
  input  logic                                R,
  input  logic                                U,
  input  logic                                D,
  output logic                                tracking,
  output logic                                snake,
  output logic [GRID_DIM-1:0][GRID_DIM-1:0]   head_position,
  output logic [2:0]                          row,
  output logic [2:0]                          col
);

  function automatic logic [GRID_DIM-1:0][GRID_DIM-1:0] onehot(input logic [2:0] r,
                                                               input logic [2:0] c);
    logic [GRID_DIM-1:0][GRID_DIM-1:0] g;
    g = '0;
    g[r][c] = 1'b1;
    return g;
  endfunction

  ht_state_t state, state_next;
  dir_t dir, pend, req;
  logic accept, tick, wall_hit;
  logic signed [3:0] row_try, col_try;
  logic [2:0] row_next, col_next;

  step_tick #(.TICK_CYCLES(TICK_CYCLES)) u_step_tick (
    .Clock (Clock),
    .reset (reset),
    .en    (state == HT_RUN),
    .tick  (tick)
  );

  always_comb begin
    req = DIR_NONE;
    if (U)      req = DIR_U;
    else if (D) req = DIR_D;
    else if (L) req = DIR_L;
    else if (R) req = DIR_R;
  end

  assign accept = (req != DIR_NONE) && (state != HT_DEAD) && !is_reverse(req, dir);

  // On a step the head moves in pend, which becomes dir on that same edge.
  // Off-grid results (-1 or 8) both read as negative in 4-bit signed.
  always_comb begin
    row_try = signed'({1'b0, row});
    col_try = signed'({1'b0, col});
    case (pend)
      DIR_U:   row_try = row_try - 4'sd1;
      DIR_D:   row_try = row_try + 4'sd1;
      DIR_L:   col_try = col_try - 4'sd1;
      DIR_R:   col_try = col_try + 4'sd1;
      default: ;
    endcase
    row_next = row_try[2:0];
    col_next = col_try[2:0];
  end

`ifdef HEAD_TRACKER_WRAP_EN
  assign wall_hit = 1'b0;
`else
  assign wall_hit = (row_try < 4'sd0) || (row_try > 4'sd7) ||
                    (col_try < 4'sd0) || (col_try > 4'sd7);
`endif

  always_ff @(posedge Clock or posedge reset) begin
    if (reset) state <= HT_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      HT_IDLE: if (accept) state_next = HT_RUN;
      HT_RUN:  if (tick && wall_hit) state_next = HT_DEAD;
      default: state_next = state;
    endcase
  end

  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      dir           <= DIR_NONE;
      pend          <= DIR_NONE;
      row           <= 3'(START_ROW);
      col           <= 3'(START_COL);
      head_position <= onehot(3'(START_ROW), 3'(START_COL));
      tracking      <= 1'b0;
      snake         <= 1'b0;
    end else begin
      tracking <= tick;
      if (accept) pend <= req;
      if (state == HT_IDLE && accept) dir <= req;
      if (tick) begin
        dir <= pend;
        if (wall_hit) begin
          snake <= 1'b1;
        end else begin
          row           <= row_next;
          col           <= col_next;
          head_position <= onehot(row_next, col_next);
        end
      end
    end
  end

endmodule

// File: tb/tb_head_tracker.sv
// Randomised and directed bench for head_tracker, compared each cycle against
// a cycle-count reference model of the snake head.
module tb_head_tracker;

  localparam int TICK = 4;
  localparam int SROW = 3;
  localparam int SCOL = 3;

  logic clock = 1'b0;
  logic reset, L, R, U, D;
  logic tracking, snake;
  logic [7:0][7:0] head_position;
  logic [2:0] row, col;

  int checks = 0;
  int errors = 0;

  // Model: mode 0 idle, 1 run, 2 dead; directions 0 none, 1 U, 2 D, 3 L, 4 R.
  int m_mode, m_dir, m_pend, m_age, m_row, m_col;
  bit m_trk, m_snk;

  head_tracker #(.TICK_CYCLES(TICK), .START_ROW(SROW), .START_COL(SCOL)) dut (
    .Clock         (clock),
    .reset         (reset),
    .L             (L),
    .R             (R),
    .U             (U),
    .D             (D),
    .tracking      (tracking),
    .snake         (snake),
    .head_position (head_position),
    .row           (row),
    .col           (col)
  );

  always #5 clock = ~clock;

  function automatic bit opposite(input int a, input int b);
    return (a != 0) && (b != 0) && (a != b) && ((a + 1) / 2 == (b + 1) / 2);
  endfunction

  task automatic modelReset;
    m_mode = 0; m_dir = 0; m_pend = 0; m_age = 0;
    m_row = SROW; m_col = SCOL; m_trk = 0; m_snk = 0;
  endtask

  task automatic modelEdge(input bit bu, input bit bd, input bit bl, input bit br);
    int want, old_dir, old_mode, nr, nc;
    want = bu ? 1 : bd ? 2 : bl ? 3 : br ? 4 : 0;
    old_dir = m_dir;
    old_mode = m_mode;
    m_trk = 0;
    if (old_mode == 1) begin
      m_age++;
      if (m_age % TICK == 0) begin
        m_dir = m_pend;
        m_trk = 1;
        nr = m_row + ((m_dir == 2) ? 1 : 0) - ((m_dir == 1) ? 1 : 0);
        nc = m_col + ((m_dir == 4) ? 1 : 0) - ((m_dir == 3) ? 1 : 0);
`ifdef HEAD_TRACKER_WRAP_EN
        m_row = (nr + 8) % 8;
        m_col = (nc + 8) % 8;
`else
        if (nr < 0 || nr > 7 || nc < 0 || nc > 7) begin
          m_snk = 1;
          m_mode = 2;
        end else begin
          m_row = nr;
          m_col = nc;
        end
`endif
      end
    end
    if (old_mode != 2 && want != 0 && !opposite(want, old_dir)) begin
      m_pend = want;
      if (old_mode == 0) begin
        m_dir = want;
        m_mode = 1;
        m_age = 0;
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [7:0][7:0] exp_hp;
    exp_hp = '0;
    exp_hp[3'(m_row)][3'(m_col)] = 1'b1;
    checks++;
    assert (row === 3'(m_row)) else begin
      errors++;
      $error("FAIL %s row: got %0d expected %0d", tag, row, m_row);
    end
    checks++;
    assert (col === 3'(m_col)) else begin
      errors++;
      $error("FAIL %s col: got %0d expected %0d", tag, col, m_col);
    end
    checks++;
    assert (tracking === m_trk) else begin
      errors++;
      $error("FAIL %s tracking: got %b expected %b", tag, tracking, m_trk);
    end
    checks++;
    assert (snake === m_snk) else begin
      errors++;
      $error("FAIL %s snake: got %b expected %b", tag, snake, m_snk);
    end
    checks++;
    assert (head_position === exp_hp) else begin
      errors++;
      $error("FAIL %s head_position: got %h expected %h", tag, head_position, exp_hp);
    end
  endtask

  // Called at a falling edge: drive buttons, advance the model, reach next falling edge.
  task automatic applyStimulus(input bit bu, input bit bd, input bit bl, input bit br);
    U = bu; D = bd; L = bl; R = br;
    modelEdge(bu, bd, bl, br);
    @(negedge clock);
  endtask

  task automatic doReset;
    reset = 1'b1;
    U = 0; D = 0; L = 0; R = 0;
    #1;
    modelReset;
    checkOutput("reset");
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic runIdle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      applyStimulus(0, 0, 0, 0);
      checkOutput(tag);
    end
  endtask

  initial begin
    U = 0; D = 0; L = 0; R = 0;
    reset = 1'b1;
    modelReset;
    @(negedge clock);
    checkOutput("reset_init");
    reset = 1'b0;

    runIdle(20, "idle");

    // Walk right into the wall, then confirm the dead state ignores buttons.
    applyStimulus(0, 0, 0, 1);
    checkOutput("press_r");
    for (int i = 0; i < TICK * 6; i++) begin
      applyStimulus(0, 0, 0, 1);
      checkOutput("run_right");
    end
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 0, 1, 0);
      checkOutput("dead_buttons");
    end

    // Reverse press ignored; U+L together resolves to U.
    doReset;
    applyStimulus(0, 0, 0, 1);
    checkOutput("rev_start");
    runIdle(TICK + 1, "rev_run");
    applyStimulus(0, 0, 1, 0);
    checkOutput("rev_left");
    runIdle(TICK, "rev_after_left");
    applyStimulus(1, 0, 1, 0);
    checkOutput("up_left");
    runIdle(2 * TICK, "up_after");

    // D pressed on the terminal-count edge applies one step later.
    doReset;
    applyStimulus(0, 0, 0, 1);
    checkOutput("edge_start");
    for (int i = 0; i < TICK && ((m_age + 1) % TICK != 0); i++) begin
      applyStimulus(0, 0, 0, 0);
      checkOutput("edge_wait");
    end
    applyStimulus(0, 1, 0, 0);
    checkOutput("edge_press_d");
    runIdle(2 * TICK, "edge_after");

    // Asynchronous reset in the middle of a count.
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    modelReset;
    checkOutput("async_reset");
    @(negedge clock);
    reset = 1'b0;
    runIdle(TICK + 2, "post_async_idle");

    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        doReset;
      end else begin
        applyStimulus($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                      $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
        checkOutput("random");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
